// File: rtl/store_buffer_coalesce_if.sv
// Bus bundle for the committed-store buffer: lookup port, push (commit) channel,
// drain (D-cache) channel and occupancy status. Names are from the buffer's side.
interface store_buffer_coalesce_if #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE    = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] i_lookup_addr;
  logic                  o_lookup_hit;
  logic [DATA_WIDTH-1:0] o_lookup_data;
  logic [BE-1:0]         o_lookup_be;

  logic                  i_push_valid;
  logic                  o_push_ready;
  logic [ADDR_WIDTH-1:0] i_push_addr;
  logic [DATA_WIDTH-1:0] i_push_data;
  logic [BE-1:0]         i_push_be;

  logic                  i_drain_en;
  logic                  o_drain_valid;
  logic                  i_drain_ready;
  logic [ADDR_WIDTH-1:0] o_drain_addr;
  logic [DATA_WIDTH-1:0] o_drain_data;
  logic [BE-1:0]         o_drain_be;

  logic [CNT_W-1:0]      o_count;
  logic                  o_full;
  logic                  o_empty;

  // Commit stage / D-cache / load pipe side.
  modport master (
    output i_lookup_addr, i_push_valid, i_push_addr, i_push_data, i_push_be,
           i_drain_en, i_drain_ready,
    input  o_lookup_hit, o_lookup_data, o_lookup_be, o_push_ready,
           o_drain_valid, o_drain_addr, o_drain_data, o_drain_be,
           o_count, o_full, o_empty
  );

  // Store buffer side.
  modport slave (
    input  i_lookup_addr, i_push_valid, i_push_addr, i_push_data, i_push_be,
           i_drain_en, i_drain_ready,
    output o_lookup_hit, o_lookup_data, o_lookup_be, o_push_ready,
           o_drain_valid, o_drain_addr, o_drain_data, o_drain_be,
           o_count, o_full, o_empty
  );
endinterface

// File: rtl/store_buffer_coalesce.sv
// Committed-store buffer: circular FIFO of word entries with per-byte enables,
// same-word coalescing into the youngest entry, byte-merged load forwarding
// (youngest store wins per lane) and in-order drain to the D-cache.
module store_buffer_coalesce #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                    clk,
  input logic                    rst,
  store_buffer_coalesce_if.slave sb
);
  localparam int unsigned BE    = DATA_WIDTH / 8;
  localparam int unsigned OFF   = $clog2(BE);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned WA_W  = ADDR_WIDTH - OFF;

  // Entry array and control state.
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [WA_W-1:0]       waddr_q [DEPTH];
  logic [WA_W-1:0]       waddr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_d  [DEPTH];
  logic [BE-1:0]         be_q    [DEPTH];
  logic [BE-1:0]         be_d    [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [PTR_W-1:0]      tail_m1;
  logic [WA_W-1:0]       push_wa;
  logic [WA_W-1:0]       lookup_wa;
  logic [DATA_WIDTH-1:0] push_mask;
  logic                  full;
  logic                  empty;
  logic                  coal_match;
  logic                  push_ready;
  logic                  push_fire;
  logic                  push_nz;
  logic                  merge;
  logic                  alloc;
  logic                  drain_valid;
  logic                  pop;
  logic [BE-1:0]         lk_be;
  logic [DATA_WIDTH-1:0] lk_data;

  function automatic logic [DATA_WIDTH-1:0] be_to_mask(input logic [BE-1:0] be);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < BE; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

  assign tail_m1   = tail_q - PTR_W'(1);
  assign push_wa   = sb.i_push_addr[ADDR_WIDTH-1:OFF];
  assign lookup_wa = sb.i_lookup_addr[ADDR_WIDTH-1:OFF];
  assign push_mask = be_to_mask(sb.i_push_be);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);

  // The count >= 2 guard keeps the head out of reach of coalescing, so the
  // drain outputs never change under a stalled handshake.
  assign coal_match = (count_q >= CNT_W'(2)) && valid_q[tail_m1] &&
                      (waddr_q[tail_m1] == push_wa);

  // Ready only looks at registered state and the push address; when full only
  // a coalescing push gets through, a same-cycle pop does not free a slot.
  assign push_ready  = !full || coal_match;
  assign push_fire   = sb.i_push_valid && push_ready;
  assign push_nz     = |sb.i_push_be;
  assign merge       = push_fire && push_nz && coal_match;
  assign alloc       = push_fire && push_nz && !coal_match;
  assign drain_valid = !empty && sb.i_drain_en;
  assign pop         = drain_valid && sb.i_drain_ready;

  // Next-state for entries, pointers and occupancy.
  always_comb begin
    valid_d = valid_q;
    waddr_d = waddr_q;
    data_d  = data_q;
    be_d    = be_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end

    if (merge) begin
      data_d[tail_m1] = (data_q[tail_m1] & ~push_mask) | (sb.i_push_data & push_mask);
      be_d[tail_m1]   = be_q[tail_m1] | sb.i_push_be;
    end

    // alloc implies not full, pop implies not empty, so tail != head here.
    if (alloc) begin
      valid_d[tail_q] = 1'b1;
      waddr_d[tail_q] = push_wa;
      data_d[tail_q]  = sb.i_push_data & push_mask;
      be_d[tail_q]    = sb.i_push_be;
      tail_d          = tail_q + PTR_W'(1);
    end

    case ({alloc, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload; only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    waddr_q <= waddr_d;
    data_q  <= data_d;
    be_q    <= be_d;
  end

  // Forwarding: walk live entries oldest to youngest so the youngest match
  // per lane overwrites older ones.
  always_comb begin
    lk_be   = '0;
    lk_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && (waddr_q[idx] == lookup_wa)) begin
        for (int unsigned b = 0; b < BE; b++) begin
          if (be_q[idx][b]) begin
            lk_be[b]         = 1'b1;
            lk_data[8*b +: 8] = data_q[idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign sb.o_lookup_be   = lk_be;
  assign sb.o_lookup_data = lk_data;
  assign sb.o_lookup_hit  = |lk_be;

  assign sb.o_push_ready  = push_ready;
  assign sb.o_drain_valid = drain_valid;
  assign sb.o_drain_addr  = empty ? '0 : (ADDR_WIDTH'(waddr_q[head_q]) << OFF);
  assign sb.o_drain_data  = empty ? '0 : data_q[head_q];
  assign sb.o_drain_be    = empty ? '0 : be_q[head_q];
  assign sb.o_count       = count_q;
  assign sb.o_full        = full;
  assign sb.o_empty       = empty;

  // Byte-offset bits of both addresses are intentionally ignored.
  if (OFF > 0) begin : g_low_bits
    logic unused_low;
    assign unused_low = ^{sb.i_push_addr[OFF-1:0], sb.i_lookup_addr[OFF-1:0]};
  end
endmodule

// File: tb/tb_store_buffer_coalesce.sv
// Bench for the store buffer: a queue of expected drain entries is built as
// stores are accepted and checked in order as the buffer drains.
module tb_store_buffer_coalesce;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned BE    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_buffer_coalesce_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sb_if ();

  store_buffer_coalesce #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BE-1:0] be;
  } entry_t;

  entry_t exp_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  logic   push_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] mask_of(input logic [BE-1:0] be);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < BE; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  // One clock: called just after a falling edge with inputs already driven.
  task automatic tick();
    logic   coal;
    entry_t e;
    #1;
    push_acc = 1'b0;
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("drain_valid", sb_if.o_drain_valid, (exp_q.size() != 0) && sb_if.i_drain_en);
      if (sb_if.i_push_valid) begin
        coal = (exp_q.size() >= 2) && (exp_q[$].addr == (sb_if.i_push_addr & ~32'h3));
        chk("push_ready", sb_if.o_push_ready, (exp_q.size() != DEPTH) || coal);
        if (sb_if.o_push_ready) begin
          push_acc = 1'b1;
          if (sb_if.i_push_be != '0) begin
            if (coal) begin
              e = exp_q[$];
              e.data = (e.data & ~mask_of(sb_if.i_push_be)) |
                       (sb_if.i_push_data & mask_of(sb_if.i_push_be));
              e.be   = e.be | sb_if.i_push_be;
              exp_q[exp_q.size()-1] = e;
            end else begin
              e.addr = sb_if.i_push_addr & ~32'h3;
              e.data = sb_if.i_push_data & mask_of(sb_if.i_push_be);
              e.be   = sb_if.i_push_be;
              exp_q.push_back(e);
            end
          end
        end
      end
      if (sb_if.o_drain_valid && sb_if.i_drain_ready) begin
        if (exp_q.size() == 0) begin
          chk("drain_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("drain_addr", sb_if.o_drain_addr, e.addr);
          chk("drain_data", sb_if.o_drain_data, e.data);
          chk("drain_be",   sb_if.o_drain_be,   e.be);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (!rst) begin
      chk("count", sb_if.o_count, exp_q.size());
      chk("empty", sb_if.o_empty, exp_q.size() == 0);
      chk("full",  sb_if.o_full,  exp_q.size() == DEPTH);
    end
  endtask

  task automatic set_push(input logic v, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BE-1:0] be);
    sb_if.i_push_valid = v;
    sb_if.i_push_addr  = a;
    sb_if.i_push_data  = d;
    sb_if.i_push_be    = be;
  endtask

  task automatic push1(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BE-1:0] be);
    set_push(1'b1, a, d, be);
    tick();
    set_push(1'b0, '0, '0, '0);
  endtask

  task automatic lookup(input string tag, input logic [AW-1:0] a, input logic hit,
                        input logic [DW-1:0] d, input logic [BE-1:0] be);
    sb_if.i_lookup_addr = a;
    #1;
    chk({tag, "_hit"},  sb_if.o_lookup_hit,  hit);
    chk({tag, "_data"}, sb_if.o_lookup_data, d);
    chk({tag, "_be"},   sb_if.o_lookup_be,   be);
  endtask

  task automatic drain_all();
    int budget;
    budget = 100;
    set_push(1'b0, '0, '0, '0);
    sb_if.i_drain_en    = 1'b1;
    sb_if.i_drain_ready = 1'b1;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_all_left", exp_q.size(), 0);
    sb_if.i_drain_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int budget;
    set_push(1'b0, '0, '0, '0);
    sb_if.i_lookup_addr = '0;
    sb_if.i_drain_en    = 1'b0;
    sb_if.i_drain_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tick();

    // Reset then idle, with drain permitted.
    rst = 1'b0;
    sb_if.i_drain_en    = 1'b1;
    sb_if.i_drain_ready = 1'b1;
    tick();
    chk("rst_empty", sb_if.o_empty, 1);
    chk("rst_count", sb_if.o_count, 0);
    chk("rst_ready", sb_if.o_push_ready, 1);
    chk("rst_dvalid", sb_if.o_drain_valid, 0);
    lookup("rst_lk", 32'h100, 1'b0, '0, '0);
    sb_if.i_drain_en = 1'b0;

    // Reset wins over a same-cycle push, and clears a live entry.
    push1(32'h40, 32'h5555_5555, 4'hF);
    rst = 1'b1;
    set_push(1'b1, 32'h100, 32'h1234_5678, 4'hF);
    tick();
    rst = 1'b0;
    set_push(1'b0, '0, '0, '0);
    tick();
    chk("tie_count", sb_if.o_count, 0);
    chk("tie_empty", sb_if.o_empty, 1);
    lookup("tie_lk", 32'h100, 1'b0, '0, '0);
    lookup("tie_lk40", 32'h40, 1'b0, '0, '0);

    // Forwarding, younger bytes win.
    push1(32'h100, 32'hAABB_CCDD, 4'hF);
    push1(32'h100, 32'h0000_1122, 4'h3);
    lookup("fwd", 32'h102, 1'b1, 32'hAABB_1122, 4'hF);
    lookup("fwd_miss", 32'h200, 1'b0, '0, '0);
    drain_all();

    // Coalescing into the youngest entry.
    push1(32'h10, 32'h1111_1111, 4'h1);
    push1(32'h20, 32'h2222_2222, 4'h1);
    push1(32'h20, 32'h3333_3333, 4'h2);
    chk("coal_count", sb_if.o_count, 2);
    lookup("coal_lk", 32'h20, 1'b1, 32'h0000_3322, 4'h3);
    drain_all();

    // Zero byte-enable push completes without effect.
    push1(32'h80, 32'hFFFF_FFFF, 4'h0);
    chk("be0_count", sb_if.o_count, 0);

    // Fill, backpressure, coalesce while full, no same-cycle slot reuse.
    for (i = 0; i < DEPTH; i++) push1(32'h1000 + 4*i, 32'h0101_0101 * (i + 1), 4'hF);
    chk("full_flag", sb_if.o_full, 1);
    set_push(1'b0, 32'h2000, 32'h0, 4'hF);
    #1 chk("full_ready_new", sb_if.o_push_ready, 0);
    sb_if.i_push_addr = 32'h101C;
    #1 chk("full_ready_last", sb_if.o_push_ready, 1);
    push1(32'h101C, 32'h0000_00EE, 4'h1);
    sb_if.i_drain_en    = 1'b1;
    sb_if.i_drain_ready = 1'b1;
    set_push(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF);
    #1 chk("full_pop_refuse", sb_if.o_push_ready, 0);
    tick();
    sb_if.i_drain_en = 1'b0;
    tick();
    chk("full_retry_acc", push_acc, 1);
    set_push(1'b0, '0, '0, '0);
    chk("full_refill", sb_if.o_count, 8);
    drain_all();

    // Drain stall: head outputs hold.
    push1(32'h3000, 32'h1234_5678, 4'hF);
    push1(32'h3004, 32'h9ABC_DEF0, 4'hC);
    sb_if.i_drain_en    = 1'b1;
    sb_if.i_drain_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_addr", sb_if.o_drain_addr, 32'h3000);
      chk("stall_data", sb_if.o_drain_data, 32'h1234_5678);
      chk("stall_be",   sb_if.o_drain_be,   4'hF);
    end

    // Streaming through the pointer wrap with random cache backpressure.
    i = 0;
    budget = 400;
    while (i < 20 && budget > 0) begin
      set_push(1'b1, 32'h4000 + 4*i, $urandom, 4'($urandom_range(1, 15)));
      sb_if.i_drain_ready = 1'($urandom_range(0, 1));
      tick();
      if (push_acc) i++;
      budget--;
    end
    chk("wrap_pushed", i, 20);
    drain_all();
    chk("wrap_count", sb_if.o_count, 0);
    chk("wrap_empty", sb_if.o_empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
